stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  N-channel, W-bit streaming multiplexer with a valid/ready handshake and a registered output.
//  Successor to the combinational 4x4 mux.
//  Two selection modes:
//   - SELECT: the sel port picks the channel.
//   - ROUND_ROBIN: fair rotation over channels that have valid data.
//  Sits between multiple producers and one consumer in the datapath.
// PARAMETERS
//  N   4                    number of input channels (>=1)
//  W   4                    data width per channel (>=1)
//  CW  max(1,$clog2(N))     channel-index width (derived; do not override)
// PORTS
//  clk        in   1     single clock; all state updates on rising edge
//  rst        in   1     synchronous, active-high reset
//  mode       in   1     0 = SELECT, 1 = ROUND_ROBIN
//  sel        in   CW    channel select, used in SELECT mode only
//  in_valid   in   N     per-channel valid
//  in_data    in   N*W   channel i occupies bits [i*W +: W]
//  in_ready   out  N     per-channel ready; at most one bit set (one-hot or zero)
//  out_valid  out  1     output register holds a word
//  out_data   out  W     held data word
//  out_ch     out  CW    index of the channel the held word came from
//  out_ready  in   1     consumer accepts the held word when out_valid && out_ready
// BEHAVIOUR
//  Reset (rst=1 at a clock edge):
//   - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//   - in_ready=0 while rst is high.
//   - A held word is discarded, even mid-transfer.
//  Load enable: load = !out_valid || out_ready.
//   - Pass-through with no bubble: a word is consumed and a new one loaded in the same cycle.
//  Grant g (combinational):
//   - SELECT: g = sel when sel<N and in_valid[sel]=1; otherwise no grant.
//     sel>=N (non-power-of-2 N) never grants.
//   - ROUND_ROBIN: first i with in_valid[i]=1, searching rr_ptr, rr_ptr+1, ... N-1, 0, ... (wraps).
//     No grant when in_valid is all zero.
//  in_ready[g] = load && grant exists && !rst. All other in_ready bits are 0.
//  Input transfer: in_valid[g] && in_ready[g].
//   - At the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//  Latency: exactly 1 cycle from input transfer to out_valid.
//  load=1 with no grant: out_valid <= 0 (if the word was consumed) or stays 0.
//  out_valid=1 && out_ready=0: out_data and out_ch hold, and in_ready is all zero.
//  rr_ptr:
//   - After a ROUND_ROBIN transfer: rr_ptr <= (g==N-1) ? 0 : g+1.
//   - Unchanged in SELECT mode and on cycles with no transfer.
//  Changes to mode or sel act on the next grant evaluation only; they never alter a held word.
//  N=1: channel 0 is always the candidate; rr_ptr stays 0.
//  Producers must hold in_data stable while in_valid=1 and they are not granted.
// TESTING (N=4, W=4; ch0=4'hF, ch1=4'h0, ch2=4'hA, ch3=4'h6)
//  1. SELECT, all valid, out_ready=1, sel=0,1,2,3 on successive cycles
//     -> out_data F,0,A,6 each one cycle later; out_ch 0,1,2,3.
//  2. ROUND_ROBIN, all valid, out_ready=1 for 6 cycles
//     -> out_ch 0,1,2,3,0,1 (wrap); exactly one in_ready bit high each cycle.
//  3. ROUND_ROBIN, in_valid=4'b1010, rr_ptr=0
//     -> grants ch1 then ch3 then ch1; ch0 and ch2 never get in_ready.
//  4. Backpressure: out_valid=1 with ch2 (A), out_ready=0 for 3 cycles
//     -> out_data stays A, in_ready=0; out_ready=1 with ch3 valid -> next word 6, no bubble.
//  5. Reset mid-stream: rst=1 for 1 cycle while out_valid=1
//     -> out_valid=0, out_data=0, out_ch=0; next RR grant starts at ch0.
//  6. SELECT, sel=2, in_valid[2]=0 -> no in_ready; out_valid drops to 0 after the held word drains.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit valid/ready stream multiplexer with a
// single registered output stage. The winning channel is chosen either by an
// explicit select input or by a fair round-robin rotation over the channels
// that currently present valid data.
module stream_mux_rr #(
    parameter  int N  = 4,
    parameter  int W  = 4,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [CW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [CW-1:0]  out_ch,
    input  logic           out_ready
);

    typedef enum logic {
        MODE_SELECT      = 1'b0,
        MODE_ROUND_ROBIN = 1'b1
    } mode_e;

    logic [CW-1:0] rr_ptr;
    logic          load;
    logic          grant_valid;
    logic [CW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic [N-1:0]  grant_onehot;

    // The output register may take a new word when it is empty or its word is leaving.
    assign load = !out_valid || out_ready;

    // Pick the candidate channel: explicit select, or first valid channel from rr_ptr onward.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        if (mode_e'(mode) == MODE_SELECT) begin
            for (int i = 0; i < N; i++) begin
                if (sel == CW'(i) && in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CW'(i);
                    grant_data  = in_data[i*W +: W];
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!grant_valid && in_valid[(int'(rr_ptr) + k) % N]) begin
                    grant_valid = 1'b1;
                    grant_idx   = CW'((int'(rr_ptr) + k) % N);
                    grant_data  = in_data[((int'(rr_ptr) + k) % N)*W +: W];
                end
            end
        end
    end

    // Only the granted channel sees ready, and only when the output stage can accept it.
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == CW'(i)) begin
                grant_onehot[i] = 1'b1;
            end
        end
        in_ready = (load && grant_valid && !rst) ? grant_onehot : '0;
    end

    // Output register and round-robin pointer; a held word is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (load) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_data <= grant_data;
                out_ch   <= grant_idx;
                if (mode_e'(mode) == MODE_ROUND_ROBIN) begin
                    rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + CW'(1);
                end
            end
        end
    end

endmodule
